sr_multicycle: RTL and testbench

//  Iterative 32-bit right shifter (logical or arithmetic) for the ALU shift path;
//  the right-direction counterpart of the fixed left-shift stages.

---
 rtl/shift_pkg.sv | 16 +
 rtl/sr_stage_mux.sv | 29 ++
 rtl/sr_multicycle.sv | 93 +++++++++
 tb/tb_sr_multicycle.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants and FSM state type for the shift paths.
package shift_pkg;

  localparam int WIDTH        = 32;
  localparam int AMT_W        = 5;
  localparam int SHIFT_STAGES = 5;
  localparam int STAGE_MAX    = 4;
  localparam int STAGE_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sr_state_e;

endpackage

// File: rtl/sr_stage_mux.sv
// One power-of-two right-shift stage: shifts by 2^stage_i with fill_i when en_i,
// otherwise passes the operand through unchanged.
module sr_stage_mux
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0]   data_i,
  input  logic [STAGE_W-1:0] stage_i,
  input  logic               fill_i,
  input  logic               en_i,
  output logic [WIDTH-1:0]   data_o
);

  logic [WIDTH-1:0] cand [SHIFT_STAGES];

  for (genvar gi = 0; gi < SHIFT_STAGES; gi++) begin : g_cand
    localparam int DIST = 1 << gi;
    assign cand[gi] = {{DIST{fill_i}}, data_i[WIDTH-1:DIST]};
  end

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      for (int i = 0; i < SHIFT_STAGES; i++) begin
        if (stage_i == STAGE_W'(i)) data_o = cand[i];
      end
    end
  end

endmodule

// File: rtl/sr_multicycle.sv
// Iterative right shifter, one stage (16,8,4,2,1) per cycle, start/ready handshake.
// Optional SR_EARLY_EXIT_EN: finish as soon as no lower amount bits remain.
module sr_multicycle
  import shift_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [AMT_W-1:0] ctrl_shiftamt,
  input  logic             ctrl_arith,
  output logic             busy,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] data_result
);

  sr_state_e          state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic               fill_q, fill_d;
  logic [WIDTH-1:0]   stage_out;
  logic               last_stage;

  sr_stage_mux u_stage_mux (
    .data_i  (acc_q),
    .stage_i (stage_q),
    .fill_i  (fill_q),
    .en_i    (rem_q[stage_q]),
    .data_o  (stage_out)
  );

`ifdef SR_EARLY_EXIT_EN
  logic [AMT_W-1:0] low_mask;
  // Bits below the current stage; when none are set the remaining stages are no-ops.
  assign low_mask   = (AMT_W'(1) << stage_q) - AMT_W'(1);
  assign last_stage = (stage_q == '0) || ((rem_q & low_mask) == '0);
`else
  assign last_stage = (stage_q == '0);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    stage_d = stage_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (ctrl_start) begin
          acc_d   = data_operandA;
          rem_d   = ctrl_shiftamt;
          fill_d  = ctrl_arith & data_operandA[WIDTH-1];
          stage_d = STAGE_W'(STAGE_MAX);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = stage_out;
        if (last_stage) begin
          stage_d = STAGE_W'(STAGE_MAX);
          state_d = DONE;
        end else begin
          stage_d = stage_q - STAGE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      stage_q <= STAGE_W'(STAGE_MAX);
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      stage_q <= stage_d;
      fill_q  <= fill_d;
    end
  end

  assign busy           = (state_q == SHIFT);
  assign data_resultRDY = (state_q == DONE);
  assign data_result    = acc_q;

endmodule

// File: tb/tb_sr_multicycle.sv
// Self-checking bench for sr_multicycle: directed literal cases plus randomized traffic
// checked every cycle against a behavioural model.
module tb_sr_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] opa = '0;
  logic [4:0]  amt = '0;
  logic        arith = 1'b0;
  logic        busy_o, rdy_o;
  logic [31:0] res_o;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  sr_multicycle dut (
    .clock          (clk),
    .reset          (rst_n),
    .ctrl_start     (start),
    .data_operandA  (opa),
    .ctrl_shiftamt  (amt),
    .ctrl_arith     (arith),
    .busy           (busy_o),
    .data_resultRDY (rdy_o),
    .data_result    (res_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(logic [31:0] a, int sh, bit ar);
    logic signed [31:0] s;
    s = a;
    if (ar) return s >>> sh;
    return a >> sh;
  endfunction

  function automatic int ref_lat(int sh);
`ifdef SR_EARLY_EXIT_EN
    if (sh == 0) return 1;
    for (int k = 0; k < 5; k++) if (sh[k]) return 5 - k;
`endif
    return 5;
  endfunction

  // Behavioural model: cycles left until ready, pending and visible result.
  int          m_left = 0;
  bit          m_rdy = 1'b0;
  bit          m_known = 1'b1;
  logic [31:0] m_cur = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_rdy = 1'b0; m_cur = '0; m_known = 1'b1;
    end else if (m_left == 0 && start) begin
      m_left  = ref_lat(int'(amt));
      m_pend  = ref_shift(opa, int'(amt), arith);
      m_rdy   = 1'b0;
      m_known = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_rdy  = (m_left == 0);
      if (m_rdy) begin
        m_cur = m_pend; m_known = 1'b1;
      end
    end else begin
      m_rdy = 1'b0;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy_o), 32'(m_left > 0));
      chk("rdy", 32'(rdy_o), 32'(m_rdy));
      if (m_known) chk("result", res_o, m_cur);
    end
  end

  task automatic wait_rdy(output int n);
    n = 0;
    while (!rdy_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!rdy_o) chk("rdy_timeout", 32'(rdy_o), 32'd1);
  endtask

  task automatic run_op(logic [31:0] a, logic [4:0] sh, bit ar,
                        logic [31:0] exp_res, int exp_lat, string name);
    int n;
    @(posedge clk); #1;
    start = 1'b1; opa = a; amt = sh; arith = ar;
    @(posedge clk); #1;
    start = 1'b0;
    wait_rdy(n);
    chk({name, "_res"}, res_o, exp_res);
    chk({name, "_lat"}, 32'(n), 32'(exp_lat));
    $display("op %s: A=0x%08h amt=%0d arith=%0d -> 0x%08h after %0d cycles", name, a, sh, ar, res_o, n);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_rdy", 32'(rdy_o), 32'd0);
    chk("reset_result", res_o, 32'd0);
    rst_n = 1'b1;

    run_op(32'hF0F0F0F0, 5'd4,  1'b0, 32'h0F0F0F0F, ref_lat(4), "t1");
    run_op(32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 5, "t2a");
    run_op(32'h80000000, 5'd31, 1'b0, 32'h00000001, 5, "t2b");
`ifdef SR_EARLY_EXIT_EN
    run_op(32'h12345678, 5'd0,  1'b1, 32'h12345678, 1, "t3");
    run_op(32'hFFFF0000, 5'd16, 1'b0, 32'h0000FFFF, 1, "t6a");
`else
    run_op(32'h12345678, 5'd0,  1'b1, 32'h12345678, 5, "t3");
    run_op(32'hFFFF0000, 5'd16, 1'b0, 32'h0000FFFF, 5, "t6a");
`endif
    run_op(32'hFFFF0000, 5'd1,  1'b0, 32'h7FFF8000, 5, "t6b");

    // Start while busy is ignored; start during DONE is accepted back-to-back.
    @(posedge clk); #1;
    start = 1'b1; opa = 32'hF0F0F0F0; amt = 5'd4; arith = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; opa = 32'h0; amt = 5'd0;
    @(posedge clk); #1; start = 1'b0;
    wait_rdy(n);
    chk("t4_first", res_o, 32'h0F0F0F0F);
    $display("op t4a: first result 0x%08h", res_o);
    start = 1'b1; opa = 32'h80000000; amt = 5'd31; arith = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("t4_b2b_busy", 32'(busy_o), 32'd1);
    wait_rdy(n);
    chk("t4_second", res_o, 32'hFFFFFFFF);
    $display("op t4b: second result 0x%08h", res_o);

    // Reset in the middle of a shift aborts it.
    @(posedge clk); #1;
    start = 1'b1; opa = 32'hDEADBEEF; amt = 5'd1; arith = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_rdy", 32'(rdy_o), 32'd0);
    chk("t5_result", res_o, 32'd0);
    $display("op t5: reset mid-shift, result 0x%08h", res_o);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(32'hDEADBEEF, 5'd8, 1'b1, 32'hFFDEADBE, ref_lat(8), "t5b");

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      opa   = $urandom;
      amt   = 5'($urandom_range(0, 31));
      arith = 1'($urandom_range(0, 1));
      if (start && m_left == 0)
        $display("rand op: A=0x%08h amt=%0d arith=%0d exp=0x%08h", opa, amt, arith,
                 ref_shift(opa, int'(amt), arith));
    end
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
